// File: rtl/spi_rx_pack_fifo_if.sv
// Receive-side FIFO bus: shift-engine strobes in, register-block read port and flags out.
// master drives the strobes/controls, slave is the buffer itself.
interface spi_rx_pack_fifo_if #(
  parameter int unsigned LW = 3
);
  logic          enable;
  logic [3:0]    char_len;
  logic          char_done;
  logic [15:0]   rchar;
  logic          frame_end;
  logic [LW-1:0] rxthr;
  logic          rd;
  logic [31:0]   rdata;
  logic          rne;
  logic          rxf;
  logic          rxt;
  logic          ovf;
  logic [LW-1:0] level;

  modport master (
    output enable, char_len, char_done, rchar, frame_end, rxthr, rd,
    input  rdata, rne, rxf, rxt, ovf, level
  );

  modport slave (
    input  enable, char_len, char_done, rchar, frame_end, rxthr, rd,
    output rdata, rne, rxf, rxt, ovf, level
  );
endinterface

// File: rtl/spi_rx_pack_fifo.sv
// SPI receive buffer: packs received characters into 32-bit words and queues them in a FIFO.
// Define SPI_RX_PACK_EN for byte/halfword lane packing; otherwise one char per word.
module spi_rx_pack_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = 3
) (
  input logic              s_sysclk,
  input logic              s_reset,
  spi_rx_pack_fifo_if.slave bus
);

  localparam int unsigned AW = LW - 1;

  logic          clear;
  logic [3:0]    eff_len;
  logic [15:0]   char_masked;
  logic          push;
  logic [31:0]   push_word;

  logic [31:0]   mem_q [DEPTH];
  logic [LW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [LW-1:0] level, level_d;
  logic          full, pop, push_ok, ovf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rne_q, rxf_q, rxt_q, ovf_q;

  assign clear = s_reset || !bus.enable;

`ifdef SPI_RX_PACK_EN
  logic [1:0]  lane_q, lane_d;
  logic [31:0] acc_q, acc_d, packed_word;
  logic [3:0]  len_q, len_d;
  logic        last_lane;

  always_comb begin
    // Length is latched at lane 0 so a mid-word change cannot split lanes.
    eff_len     = (lane_q == 2'd0) ? bus.char_len : len_q;
    char_masked = bus.rchar & (16'hffff >> (4'd15 - eff_len));
    lane_d      = lane_q;
    acc_d       = acc_q;
    len_d       = len_q;
    push        = 1'b0;
    push_word   = acc_q;
    packed_word = acc_q;
    last_lane   = 1'b0;
    if (eff_len[3]) begin
      packed_word = acc_q | (lane_q[0] ? {char_masked, 16'h0} : {16'h0, char_masked});
      last_lane   = lane_q[0];
    end else begin
      packed_word = acc_q | ({24'h0, char_masked[7:0]} << {lane_q, 3'b000});
      last_lane   = (lane_q == 2'd3);
    end
    if (bus.char_done) begin
      if (last_lane || bus.frame_end) begin
        push      = 1'b1;
        push_word = packed_word;
        lane_d    = 2'd0;
        acc_d     = '0;
      end else begin
        acc_d  = packed_word;
        lane_d = lane_q + 2'd1;
        len_d  = eff_len;
      end
    end else if (bus.frame_end && lane_q != 2'd0) begin
      push      = 1'b1;
      push_word = acc_q;
      lane_d    = 2'd0;
      acc_d     = '0;
    end
  end

  always_ff @(posedge s_sysclk) begin
    if (clear) begin
      lane_q <= '0;
      acc_q  <= '0;
      len_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
      len_q  <= len_d;
    end
  end
`else
  always_comb begin
    eff_len     = bus.char_len;
    char_masked = bus.rchar & (16'hffff >> (4'd15 - eff_len));
    push        = bus.char_done;
    push_word   = {16'h0, char_masked};
  end
`endif

  always_comb begin
    level   = wr_q - rd_q;
    full    = (level == LW'(DEPTH));
    pop     = bus.rd && (level != '0);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    push_ok = push && (!full || pop);
    ovf_d   = push && full && !pop;
    wr_d    = wr_q + LW'(push_ok);
    rd_d    = rd_q + LW'(pop);
    level_d = wr_d - rd_d;
    if (level_d == '0) begin
      rdata_d = '0;
    end else if (push_ok && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
      rdata_d = push_word;
    end else begin
      rdata_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge s_sysclk) begin
    if (clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      rne_q   <= 1'b0;
      rxf_q   <= 1'b0;
      rxt_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      rne_q   <= (level_d != '0);
      rxf_q   <= (level_d == LW'(DEPTH));
      rxt_q   <= (level_d >= bus.rxthr) && (level_d != '0);
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge s_sysclk) begin
    if (!clear && push_ok) begin
      mem_q[wr_q[AW-1:0]] <= push_word;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rne   = rne_q;
  assign bus.rxf   = rxf_q;
  assign bus.rxt   = rxt_q;
  assign bus.ovf   = ovf_q;
  assign bus.level = level;

endmodule
